axi_ddrx_cmd_arbiter: RTL and testbench



---
 rtl/axi_ddrx_cmd_arbiter_if.sv | 43 ++++
 rtl/axi_ddrx_cmd_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_ddrx_cmd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ddrx_cmd_arbiter_if.sv
// AXI AW/AR address channels plus the DDRx native command port of axi_ddrx_cmd_arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface axi_ddrx_cmd_arbiter_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_ID_WIDTH   = 3,
    parameter int C_LEN_WIDTH  = 8
);
    logic [C_ID_WIDTH-1:0]   s_axi_awid;
    logic [C_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [C_LEN_WIDTH-1:0]  s_axi_awlen;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;

    logic [C_ID_WIDTH-1:0]   s_axi_arid;
    logic [C_ADDR_WIDTH-1:0] s_axi_araddr;
    logic [C_LEN_WIDTH-1:0]  s_axi_arlen;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_wr;
    logic [C_ADDR_WIDTH-1:0] cmd_addr;
    logic [C_LEN_WIDTH-1:0]  cmd_len;
    logic [C_ID_WIDTH-1:0]   cmd_id;
    logic                    cmd_last;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  cmd_ready,
        output s_axi_awready, s_axi_arready,
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_id, cmd_last
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output cmd_ready,
        input  s_axi_awready, s_axi_arready,
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_id, cmd_last
    );
endinterface

// File: rtl/axi_ddrx_cmd_arbiter.sv
// AW/AR arbiter and boundary burst splitter feeding the DDRx native command port.
// Optional grant statistics counters are enabled with the ARB_STATS_EN macro.
module axi_ddrx_cmd_arbiter #(
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_ID_WIDTH        = 3,
    parameter int C_LEN_WIDTH       = 8,
    parameter int C_DATA_BYTES_LOG2 = 2,
    parameter int C_SPLIT_LOG2      = 10,
    parameter int C_ARB_MODE        = 1,
    parameter int C_WR_STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    axi_ddrx_cmd_arbiter_if.slave bus,
    output logic dbg_state
`ifdef ARB_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [31:0] stat_rd_grants,
    output logic [31:0] stat_wr_grants
`endif
);
    localparam int LW = C_LEN_WIDTH;
    localparam int CW = (LW + 1 > C_SPLIT_LOG2 + 1) ? LW + 1 : C_SPLIT_LOG2 + 1;
    localparam logic [7:0] STARVE_LIM = 8'(C_WR_STARVE_LIMIT);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [LW:0]     rem;
    logic            rr_last_wr;
    logic [7:0]      starve_cnt;

    logic                    grant_wr;
    logic                    grant_fire;
    logic [C_ADDR_WIDTH-1:0] sel_addr;
    logic [LW-1:0]           sel_len;
    logic [C_ID_WIDTH-1:0]   sel_id;
    logic [LW:0]             sel_beats;
    logic [LW:0]             first_beats;
    logic [LW:0]             cur_beats;
    logic [C_ADDR_WIDTH-1:0] nxt_addr;
    logic [LW:0]             nxt_rem;
    logic [LW:0]             nxt_beats;

    // Beats of one piece: the rest of the burst, capped at the distance to the next boundary.
    function automatic logic [LW:0] piece_beats(input logic [C_SPLIT_LOG2-1:0] off,
                                                input logic [LW:0] remain);
        logic [CW-1:0] bytes_to_bnd;
        logic [CW-1:0] beats_to_bnd;
        bytes_to_bnd = (CW'(1) << C_SPLIT_LOG2) - CW'(off);
        beats_to_bnd = bytes_to_bnd >> C_DATA_BYTES_LOG2;
        if (CW'(remain) < beats_to_bnd) piece_beats = remain;
        else                            piece_beats = beats_to_bnd[LW:0];
    endfunction

    always_comb begin
        grant_wr = 1'b0;
        if (C_ARB_MODE == 0) begin
            if (bus.s_axi_awvalid && bus.s_axi_arvalid) grant_wr = !rr_last_wr;
            else                                        grant_wr = bus.s_axi_awvalid;
        end else begin
            grant_wr = bus.s_axi_awvalid && (!bus.s_axi_arvalid || starve_cnt >= STARVE_LIM);
        end
    end

    // No new grant while a ready pulse is out: the master still shows the accepted request.
    assign grant_fire = (state == IDLE) && (bus.s_axi_awvalid || bus.s_axi_arvalid) &&
                        !bus.s_axi_awready && !bus.s_axi_arready;

    assign sel_addr    = grant_wr ? bus.s_axi_awaddr : bus.s_axi_araddr;
    assign sel_len     = grant_wr ? bus.s_axi_awlen  : bus.s_axi_arlen;
    assign sel_id      = grant_wr ? bus.s_axi_awid   : bus.s_axi_arid;
    assign sel_beats   = {1'b0, sel_len} + 1'b1;
    assign first_beats = piece_beats(sel_addr[C_SPLIT_LOG2-1:0], sel_beats);

    assign cur_beats = {1'b0, bus.cmd_len} + 1'b1;
    assign nxt_addr  = bus.cmd_addr + (C_ADDR_WIDTH'(cur_beats) << C_DATA_BYTES_LOG2);
    assign nxt_rem   = rem - cur_beats;
    assign nxt_beats = piece_beats(nxt_addr[C_SPLIT_LOG2-1:0], nxt_rem);

    assign dbg_state = (state == ISSUE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rem               <= '0;
            rr_last_wr        <= 1'b1;
            starve_cnt        <= '0;
            bus.s_axi_awready <= 1'b0;
            bus.s_axi_arready <= 1'b0;
            bus.cmd_valid     <= 1'b0;
            bus.cmd_wr        <= 1'b0;
            bus.cmd_addr      <= '0;
            bus.cmd_len       <= '0;
            bus.cmd_id        <= '0;
            bus.cmd_last      <= 1'b0;
        end else begin
            bus.s_axi_awready <= 1'b0;
            bus.s_axi_arready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        state         <= ISSUE;
                        bus.cmd_valid <= 1'b1;
                        bus.cmd_wr    <= grant_wr;
                        bus.cmd_id    <= sel_id;
                        bus.cmd_addr  <= sel_addr;
                        bus.cmd_len   <= LW'(first_beats - 1'b1);
                        bus.cmd_last  <= (first_beats == sel_beats);
                        rem           <= sel_beats;
                        rr_last_wr    <= grant_wr;
                        if (grant_wr || !bus.s_axi_awvalid) starve_cnt <= '0;
                        else if (starve_cnt < STARVE_LIM)   starve_cnt <= starve_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        if (bus.cmd_last) begin
                            state         <= IDLE;
                            bus.cmd_valid <= 1'b0;
                            if (bus.cmd_wr) bus.s_axi_awready <= 1'b1;
                            else            bus.s_axi_arready <= 1'b1;
                        end else begin
                            bus.cmd_addr <= nxt_addr;
                            bus.cmd_len  <= LW'(nxt_beats - 1'b1);
                            bus.cmd_last <= (nxt_beats == nxt_rem);
                            rem          <= nxt_rem;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_rd_grants <= '0;
            stat_wr_grants <= '0;
        end else if (grant_fire) begin
            if (grant_wr && stat_wr_grants != 32'hFFFF_FFFF)
                stat_wr_grants <= stat_wr_grants + 32'd1;
            if (!grant_wr && stat_rd_grants != 32'hFFFF_FFFF)
                stat_rd_grants <= stat_rd_grants + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axi_ddrx_cmd_arbiter.sv
// Self-checking bench for axi_ddrx_cmd_arbiter: read-priority instance (limit 2) and a round-robin instance.
module tb_axi_ddrx_cmd_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dbg_main, dbg_rr;
    int   n_cmp = 0;
    int   n_err = 0;
    int   aw_pulses = 0;
    int   ar_pulses = 0;
    bit   rand_rdy = 1'b0;
    logic [44:0] exp_q[$];
    logic [0:0]  rr_q[$];
`ifdef ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic        rr_stat_clr = 1'b0;
    logic [31:0] stat_rd, stat_wr, rr_stat_rd, rr_stat_wr;
`endif

    axi_ddrx_cmd_arbiter_if #(.C_ADDR_WIDTH(32), .C_ID_WIDTH(3), .C_LEN_WIDTH(8)) bus ();
    axi_ddrx_cmd_arbiter_if #(.C_ADDR_WIDTH(32), .C_ID_WIDTH(3), .C_LEN_WIDTH(8)) rr_bus ();

    axi_ddrx_cmd_arbiter #(.C_ARB_MODE(1), .C_WR_STARVE_LIMIT(2)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_main)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_rd_grants(stat_rd), .stat_wr_grants(stat_wr)
`endif
    );

    axi_ddrx_cmd_arbiter #(.C_ARB_MODE(0), .C_WR_STARVE_LIMIT(8)) u_rr (
        .clk(clk), .reset(reset), .bus(rr_bus), .dbg_state(dbg_rr)
`ifdef ARB_STATS_EN
        , .stat_clr(rr_stat_clr), .stat_rd_grants(rr_stat_rd), .stat_wr_grants(rr_stat_wr)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [44:0] pk(input logic wr, input logic [2:0] id, input logic [31:0] a,
                                       input logic [7:0] len, input logic last);
        return {wr, id, a, len, last};
    endfunction

    // Reference split: walk the burst in byte addresses with 1 KB boundaries and 4-byte beats.
    task automatic push_txn(input logic wr, input logic [2:0] id, input logic [31:0] addr,
                            input logic [7:0] len);
        longint a = longint'(addr);
        int     n = int'(len) + 1;
        int     bnd, b;
        while (n > 0) begin
            bnd = (1024 - int'(a % 1024)) / 4;
            b   = (n < bnd) ? n : bnd;
            exp_q.push_back(pk(wr, id, a[31:0], 8'(b - 1), n == b));
            a = (a + longint'(b) * 4) & 64'hFFFF_FFFF;
            n = n - b;
        end
    endtask

    // driver tasks: present one request, hold it until ready is seen, then drop it
    task automatic drive_req(input logic wr, input logic [2:0] id, input logic [31:0] addr,
                             input logic [7:0] len, output int lat);
        if (wr) begin
            bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len; bus.s_axi_awvalid = 1'b1;
        end else begin
            bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len; bus.s_axi_arvalid = 1'b1;
        end
        lat = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (wr ? bus.s_axi_awready : bus.s_axi_arready) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check_eq(wr ? "aw_timeout" : "ar_timeout", lat, 1);
        @(posedge clk); #1;
        if (wr) bus.s_axi_awvalid = 1'b0;
        else    bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic rr_req(input logic wr, input logic [2:0] id, input logic [31:0] addr);
        int seen = 0;
        if (wr) begin
            rr_bus.s_axi_awid = id; rr_bus.s_axi_awaddr = addr; rr_bus.s_axi_awlen = 8'd0; rr_bus.s_axi_awvalid = 1'b1;
        end else begin
            rr_bus.s_axi_arid = id; rr_bus.s_axi_araddr = addr; rr_bus.s_axi_arlen = 8'd0; rr_bus.s_axi_arvalid = 1'b1;
        end
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (wr ? rr_bus.s_axi_awready : rr_bus.s_axi_arready) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) check_eq("rr_timeout", seen, 1);
        @(posedge clk); #1;
        if (wr) rr_bus.s_axi_awvalid = 1'b0;
        else    rr_bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    always begin
        @(posedge clk); #1;
        if (rand_rdy) bus.cmd_ready = 1'($urandom_range(0, 1));
    end

    // scoreboard: compare every command handshake against the expected queue
    always @(negedge clk) begin
        if (bus.s_axi_awready) aw_pulses++;
        if (bus.s_axi_arready) ar_pulses++;
        if (!reset && bus.cmd_valid && bus.cmd_ready) begin
            if (exp_q.size() == 0) check_eq("cmd_expected_avail", exp_q.size(), 1);
            else check_eq("cmd", pk(bus.cmd_wr, bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_last),
                          exp_q.pop_front());
        end
        if (!reset && rr_bus.cmd_valid && rr_bus.cmd_ready) begin
            if (rr_q.size() == 0) check_eq("rr_expected_avail", rr_q.size(), 1);
            else check_eq("rr_dir", rr_bus.cmd_wr, rr_q.pop_front());
        end
    end

    initial begin
        int lat, lat2, awp, arp;
        logic [31:0] a;
        logic wr;
        logic [7:0] len;
        bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
        bus.cmd_ready = 1'b1;
        rr_bus.s_axi_awid = '0; rr_bus.s_axi_awaddr = '0; rr_bus.s_axi_awlen = '0; rr_bus.s_axi_awvalid = 1'b0;
        rr_bus.s_axi_arid = '0; rr_bus.s_axi_araddr = '0; rr_bus.s_axi_arlen = '0; rr_bus.s_axi_arvalid = 1'b0;
        rr_bus.cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_cmd_valid", bus.cmd_valid, 0);
        check_eq("rst_fields", pk(bus.cmd_wr, bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_last), 0);
        check_eq("rst_readies", {bus.s_axi_awready, bus.s_axi_arready}, 0);
        check_eq("rst_state", dbg_main, 0);
        @(posedge clk); #1;

        // single read, accept pulse visible in the third cycle
        push_txn(1'b0, 3'd1, 32'h100, 8'd3);
        drive_req(1'b0, 3'd1, 32'h100, 8'd3, lat);
        check_eq("ar_latency", lat, 3);
        wait_drain();

        // write split across the 1 KB boundary
        awp = aw_pulses;
        push_txn(1'b1, 3'd2, 32'h3F8, 8'd7);
        drive_req(1'b1, 3'd2, 32'h3F8, 8'd7, lat);
        wait_drain();
        check_eq("aw_pulse_count", aw_pulses - awp, 1);

        // boundary-aligned max burst, one-beat-off max burst, address wrap
        push_txn(1'b0, 3'd3, 32'h400, 8'd255);
        drive_req(1'b0, 3'd3, 32'h400, 8'd255, lat);
        push_txn(1'b1, 3'd4, 32'h404, 8'd255);
        drive_req(1'b1, 3'd4, 32'h404, 8'd255, lat);
        push_txn(1'b0, 3'd5, 32'hFFFF_FFFC, 8'd1);
        drive_req(1'b0, 3'd5, 32'hFFFF_FFFC, 8'd1, lat);
        wait_drain();

        // random traffic with a randomly stalling command port
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
            len = (i % 6 == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 40));
            push_txn(wr, 3'(i), a, len);
            drive_req(wr, 3'(i), a, len, lat);
        end
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;

        // read priority with starvation limit 2: R,R,W,R,R,W
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) push_txn(1'b1, 3'(i / 3), 32'h2000 + 32'(i / 3) * 64, 8'd1);
            else push_txn(1'b0, 3'(i - i / 3), 32'h1000 + 32'(i - i / 3) * 64, 8'd3);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) drive_req(1'b0, 3'(i), 32'h1000 + 32'(i) * 64, 8'd3, lat);
            end
            begin
                for (int i = 0; i < 2; i++) drive_req(1'b1, 3'(i), 32'h2000 + 32'(i) * 64, 8'd1, lat2);
            end
        join
        wait_drain();

`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_txn(i >= 4, 3'(i), 32'h3000 + 32'(i) * 16, 8'd0);
            drive_req(i >= 4, 3'(i), 32'h3000 + 32'(i) * 16, 8'd0, lat);
        end
        wait_drain();
        check_eq("stat_rd", stat_rd, 4);
        check_eq("stat_wr", stat_wr, 2);
        stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        check_eq("stat_rd_clr", stat_rd, 0);
        check_eq("stat_wr_clr", stat_wr, 0);
`endif

        // stall mid-split, then reset abandons the transaction
        bus.cmd_ready = 1'b0;
        awp = aw_pulses;
        arp = ar_pulses;
        exp_q.push_back(pk(1'b1, 3'd5, 32'h3F8, 8'd1, 1'b0));
        bus.s_axi_awid = 3'd5; bus.s_axi_awaddr = 32'h3F8; bus.s_axi_awlen = 8'd7; bus.s_axi_awvalid = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.cmd_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) check_eq("stall_valid_timeout", lat, 1);
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_p1", pk(bus.cmd_wr, bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_last),
                     pk(1'b1, 3'd5, 32'h3F8, 8'd1, 1'b0));
            @(negedge clk);
        end
        @(posedge clk); #1 bus.cmd_ready = 1'b1;
        @(posedge clk); #1 bus.cmd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_p2", pk(bus.cmd_wr, bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_last),
                     pk(1'b1, 3'd5, 32'h400, 8'd5, 1'b1));
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_cmd_valid", bus.cmd_valid, 0);
        check_eq("rst_mid_state", dbg_main, 0);
        bus.s_axi_awvalid = 1'b0;
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_no_aw_pulse", aw_pulses - awp, 0);
        check_eq("rst_no_ar_pulse", ar_pulses - arp, 0);
        check_eq("exp_q_empty", exp_q.size(), 0);

        // round-robin instance: both channels busy, grants alternate starting with a read
        for (int i = 0; i < 6; i++) rr_q.push_back(1'(i % 2));
        fork
            begin
                for (int i = 0; i < 3; i++) rr_req(1'b0, 3'(i), 32'h500 + 32'(i) * 4);
            end
            begin
                for (int i = 0; i < 3; i++) rr_req(1'b1, 3'(i), 32'h600 + 32'(i) * 4);
            end
        join
        repeat (2) @(posedge clk);
        check_eq("rr_q_empty", rr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
